// File: rtl/tinyfpga_warmboot_ctrl.sv
// ============================================================================
// Module   : tinyfpga_warmboot_ctrl
// Brief    : Boot hand-off sequencer: USB detach, wait for flash idle, then
//            fire SB_WARMBOOT with the image select latched at acceptance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tinyfpga_warmboot_ctrl #(
   parameter int DETACH_CYCLES   = 480000,
   parameter int SPI_IDLE_CYCLES = 16,
   parameter int CNT_W           = 24
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       boot_req,
   input  logic [1:0] image_sel,
   input  logic       spi_cs,
   output logic       usb_detach,
   output logic       boot_busy,
   output logic       warmboot_boot,
   output logic       warmboot_s1,
   output logic       warmboot_s0
);

   localparam logic [1:0] c_st_idle     = 2'd0;
   localparam logic [1:0] c_st_detach   = 2'd1;
   localparam logic [1:0] c_st_wait_spi = 2'd2;
   localparam logic [1:0] c_st_boot     = 2'd3;

   // Zero-valued cycle parameters behave as one cycle.
   localparam int c_detach_eff = (DETACH_CYCLES   < 1) ? 1 : DETACH_CYCLES;
   localparam int c_idle_eff   = (SPI_IDLE_CYCLES < 1) ? 1 : SPI_IDLE_CYCLES;

   localparam logic [CNT_W-1:0] c_detach_last = CNT_W'(c_detach_eff - 1);
   localparam logic [CNT_W-1:0] c_spi_idle    = CNT_W'(c_idle_eff);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_detach;
   logic             r_busy;
   logic             r_boot;
   logic [1:0]       r_sel;
   logic [CNT_W-1:0] w_cnt_inc;

   assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= c_st_idle;
         r_cnt    <= '0;
         r_detach <= 1'b0;
         r_busy   <= 1'b0;
         r_boot   <= 1'b0;
         r_sel    <= 2'b00;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (boot_req) begin
                  r_state  <= c_st_detach;
                  r_cnt    <= '0;
                  r_detach <= 1'b1;
                  r_busy   <= 1'b1;
                  r_sel    <= image_sel;
               end
            end
            c_st_detach: begin
               if (r_cnt >= c_detach_last) begin
                  r_state <= c_st_wait_spi;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            c_st_wait_spi: begin
               // Any flash access restarts the quiet-period count.
               if (r_cnt >= c_spi_idle) begin
                  r_state <= c_st_boot;
                  r_cnt   <= '0;
                  r_boot  <= 1'b1;
               end else if (spi_cs) begin
                  r_cnt <= w_cnt_inc;
               end else begin
                  r_cnt <= '0;
               end
            end
            default: begin
               r_state <= c_st_boot;
            end
         endcase
      end
   end

   assign usb_detach    = r_detach;
   assign boot_busy     = r_busy;
   assign warmboot_boot = r_boot;
   assign warmboot_s1   = r_sel[1];
   assign warmboot_s0   = r_sel[0];

endmodule

`default_nettype wire

// File: tb/tb_tinyfpga_warmboot_ctrl.sv
// ============================================================================
// Module   : tb_tinyfpga_warmboot_ctrl
// Brief    : Scoreboard bench for the warm-boot hand-off sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tinyfpga_warmboot_ctrl;

   localparam int D   = 10;
   localparam int S   = 4;
   localparam int LAT = D + S + 1;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       boot_req = 1'b0;
   logic [1:0] image_sel = 2'b00;
   logic       spi_cs = 1'b1;
   logic       usb_detach, boot_busy, warmboot_boot, warmboot_s1, warmboot_s0;
   logic [4:0] outs;

   assign outs = {usb_detach, boot_busy, warmboot_boot, warmboot_s1, warmboot_s0};

   tinyfpga_warmboot_ctrl #(
      .DETACH_CYCLES  (D),
      .SPI_IDLE_CYCLES(S),
      .CNT_W          (24)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .boot_req     (boot_req),
      .image_sel    (image_sel),
      .spi_cs       (spi_cs),
      .usb_detach   (usb_detach),
      .boot_busy    (boot_busy),
      .warmboot_boot(warmboot_boot),
      .warmboot_s1  (warmboot_s1),
      .warmboot_s0  (warmboot_s0)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned when;
      logic [3:0]  v;
   } exp_t;

   exp_t q_det[$];
   exp_t q_boot[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every rising usb_detach / warmboot_boot must match the next expectation.
   logic prev_det = 1'b0;
   logic prev_boot = 1'b0;
   always @(negedge clk) begin
      if (usb_detach && !prev_det) begin
         if (q_det.size() == 0) begin
            chk("unexpected usb_detach rise", {31'd0, usb_detach}, 32'd0);
         end else begin
            e = q_det.pop_front();
            chk("detach cycle", cyc, e.when);
            chk("detach busy/s1/s0", {29'd0, boot_busy, warmboot_s1, warmboot_s0}, {29'd0, e.v[2:0]});
         end
      end
      if (warmboot_boot && !prev_boot) begin
         if (q_boot.size() == 0) begin
            chk("unexpected warmboot_boot rise", {31'd0, warmboot_boot}, 32'd0);
         end else begin
            e = q_boot.pop_front();
            chk("boot cycle", cyc, e.when);
            chk("boot detach/busy/s1/s0",
                {28'd0, usb_detach, boot_busy, warmboot_s1, warmboot_s0}, {28'd0, e.v});
         end
      end
      prev_det  = usb_detach;
      prev_boot = warmboot_boot;
   end

   task automatic push_boot(input int unsigned when, input logic [1:0] sel);
      exp_t x;
      x.when = when;
      x.v    = {2'b11, sel};
      q_boot.push_back(x);
   endtask

   // Returns the cycle index (as seen at negedge) right after the accepting edge.
   task automatic request(input logic [1:0] sel, input logic [1:0] sel_after,
                          output int unsigned acc);
      exp_t x;
      @(negedge clk);
      boot_req  = 1'b1;
      image_sel = sel;
      acc       = cyc + 1;
      x.when    = acc;
      x.v       = {2'b01, sel};
      q_det.push_back(x);
      @(negedge clk);
      boot_req  = 1'b0;
      image_sel = sel_after;
   endtask

   task automatic wait_boot_done();
      for (int i = 0; i < 100 && q_boot.size() != 0; i++) @(negedge clk);
      if (q_boot.size() != 0) begin
         chk("boot timeout", {31'd0, warmboot_boot}, 32'd1);
         q_boot.delete();
      end
   endtask

   task automatic do_reset(input string name);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1 chk(name, {27'd0, outs}, 32'd0);
      q_boot.delete();
      q_det.delete();
      boot_req = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   int unsigned acc;

   initial begin
      #1 chk("reset state", {27'd0, outs}, 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // 1: idle with no request
      for (int i = 0; i < 4; i++) begin
         repeat (25) @(negedge clk);
         chk("idle outputs", {27'd0, outs}, 32'd0);
      end

      // 2: single-cycle request, sel=10, flash quiet
      spi_cs = 1'b1;
      request(2'b10, 2'b00, acc);
      push_boot(acc + LAT, 2'b10);
      wait_boot_done();
      repeat (5) @(negedge clk);
      chk("boot held", {27'd0, outs}, {27'd0, 5'b11110});

      // 3: flash busy for the first four WAIT_SPI cycles
      do_reset("async reset in BOOT");
      request(2'b10, 2'b10, acc);
      while (cyc < acc + D) @(negedge clk);
      spi_cs = 1'b0;
      repeat (4) @(negedge clk);
      chk("boot low while flash busy", {27'd0, outs}, {27'd0, 5'b11010});
      spi_cs = 1'b1;
      // First edge sampling cs high is cyc+1; boot S edges later.
      push_boot(cyc + 1 + S, 2'b10);
      wait_boot_done();

      // 4: image_sel changes after acceptance
      do_reset("reset before sel test");
      request(2'b01, 2'b11, acc);
      push_boot(acc + LAT, 2'b01);
      wait_boot_done();
      repeat (3) @(negedge clk);
      chk("sel ignored after accept", {27'd0, outs}, {27'd0, 5'b11101});

      // 5: reset mid-DETACH, then full restart; reset mid-BOOT, then restart
      do_reset("reset before restart test");
      request(2'b11, 2'b00, acc);
      push_boot(acc + LAT, 2'b11);
      while (cyc < acc + 5) @(negedge clk);
      do_reset("async reset mid-DETACH");
      repeat (3) @(negedge clk);
      chk("idle after mid-DETACH reset", {27'd0, outs}, 32'd0);
      request(2'b10, 2'b00, acc);
      push_boot(acc + LAT, 2'b10);
      wait_boot_done();
      repeat (2) @(negedge clk);
      do_reset("async reset mid-BOOT");
      request(2'b01, 2'b00, acc);
      push_boot(acc + LAT, 2'b01);
      wait_boot_done();

      // 6: flash never quiet for 1000 cycles
      do_reset("reset before stall test");
      spi_cs = 1'b0;
      request(2'b10, 2'b00, acc);
      while (cyc < acc + D + 1000) @(negedge clk);
      chk("stalled in WAIT_SPI", {27'd0, outs}, {27'd0, 5'b11010});
      spi_cs = 1'b1;
      push_boot(cyc + 1 + S, 2'b10);
      wait_boot_done();

      chk("detach queue drained", q_det.size(), 32'd0);
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
